// File: rtl/bf16_pkg.sv
// Shared constants and types for the BF16 FMA command controller:
// opcode encodings, FSM state enum, queued command layout and the canonical qNaN.
package bf16_pkg;

   localparam logic [3:0] OP_FMADD  = 4'b0111;
   localparam logic [3:0] OP_FMSUB  = 4'b1000;
   localparam logic [3:0] OP_FNMSUB = 4'b1010;
   localparam logic [3:0] OP_FNMADD = 4'b1001;
   localparam logic [3:0] OP_ADD    = 4'b0100;
   localparam logic [3:0] OP_SUB    = 4'b0110;
   localparam logic [3:0] OP_MUL    = 4'b0101;

   localparam logic [15:0] BF16_QNAN = 16'h7FC0;
   localparam logic [3:0]  FPCSR_NV  = 4'b1000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   typedef struct packed {
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] c;
      logic [1:0]  tag;
   } cmd_t;

   localparam int CMD_W = $bits(cmd_t);

   function automatic logic is_legal_op(input logic [3:0] op);
      case (op)
         OP_FMADD, OP_FMSUB, OP_FNMSUB, OP_FNMADD,
         OP_ADD, OP_SUB, OP_MUL: is_legal_op = 1'b1;
         default:                is_legal_op = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/bf16_cmd_fifo.sv
// Power-of-two deep command queue; pointers wrap naturally, count tracks occupancy.
// Push is ignored when full and pop when empty, so callers may gate loosely.
module bf16_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 54
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == FULL_CNT);
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

endmodule

// File: rtl/bf16_fma_ctrl.sv
// Sequences queued BF16 FMA commands through an external datapath, one at a time,
// returning responses in order and accumulating sticky exception flags.
module bf16_fma_ctrl
   import bf16_pkg::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int FMA_LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [3:0]  cmd_op,
   input  logic [15:0] cmd_a,
   input  logic [15:0] cmd_b,
   input  logic [15:0] cmd_c,
   input  logic [1:0]  cmd_tag,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_result,
   output logic [3:0]  rsp_fpcsr,
   output logic [1:0]  rsp_tag,
   output logic        fma_enable,
   output logic [15:0] fma_operand_a,
   output logic [15:0] fma_operand_b,
   output logic [15:0] fma_operand_c,
   output logic [3:0]  fma_operation,
   input  logic [15:0] fma_result,
   input  logic [3:0]  fma_fpcsr,
   output logic [3:0]  sticky_fpcsr,
   input  logic        sticky_clear,
   output logic        busy,
   output state_e      dbg_state
);

   localparam int CNT_W = (FMA_LATENCY > 1) ? $clog2(FMA_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FMA_LATENCY - 1);

   // Both channels: a transfer happens on a rising edge where valid && ready;
   // valid and its payload stay stable until that edge, ready never waits on valid.

   logic       fifo_full, fifo_empty, fifo_pop;
   logic [CMD_W-1:0] fifo_rd_data;
   cmd_t       head;

   state_e     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [15:0] opa_q, opa_d, opb_q, opb_d, opc_q, opc_d;
   logic [3:0]  op_q, op_d;
   logic [1:0]  tag_q, tag_d;
   logic        fma_en_q, fma_en_d;
   logic [15:0] rsp_result_q, rsp_result_d;
   logic [3:0]  rsp_fpcsr_q, rsp_fpcsr_d;
   logic [1:0]  rsp_tag_q, rsp_tag_d;
   logic [3:0]  sticky_q, sticky_d;
   logic        capture;
   logic [3:0]  cap_fpcsr;

   bf16_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (CMD_W)
   ) u_cmd_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (cmd_valid),
      .wr_data ({cmd_op, cmd_a, cmd_b, cmd_c, cmd_tag}),
      .pop     (fifo_pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign head = cmd_t'(fifo_rd_data);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      opa_d        = opa_q;
      opb_d        = opb_q;
      opc_d        = opc_q;
      op_d         = op_q;
      tag_d        = tag_q;
      fma_en_d     = 1'b0;
      rsp_result_d = rsp_result_q;
      rsp_fpcsr_d  = rsp_fpcsr_q;
      rsp_tag_d    = rsp_tag_q;
      fifo_pop     = 1'b0;
      capture      = 1'b0;
      cap_fpcsr    = 4'b0000;

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               opa_d    = head.a;
               opb_d    = head.b;
               opc_d    = head.c;
               op_d     = head.op;
               tag_d    = head.tag;
               if (is_legal_op(head.op)) begin
                  state_d  = ST_ISSUE;
                  fma_en_d = 1'b1;
               end else begin
                  // Illegal opcodes never reach the datapath; answer with invalid-op qNaN.
                  state_d      = ST_DONE;
                  rsp_result_d = BF16_QNAN;
                  rsp_fpcsr_d  = FPCSR_NV;
                  rsp_tag_d    = head.tag;
                  capture      = 1'b1;
                  cap_fpcsr    = FPCSR_NV;
               end
            end
         end
         ST_ISSUE: begin
            cnt_d   = CNT_LOAD;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_d      = ST_DONE;
               rsp_result_d = fma_result;
               rsp_fpcsr_d  = fma_fpcsr;
               rsp_tag_d    = tag_q;
               capture      = 1'b1;
               cap_fpcsr    = fma_fpcsr;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_DONE: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A clear that coincides with a capture keeps only the new flags.
      if (sticky_clear) begin
         sticky_d = cap_fpcsr;
      end else begin
         sticky_d = sticky_q | cap_fpcsr;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         opa_q        <= '0;
         opb_q        <= '0;
         opc_q        <= '0;
         op_q         <= '0;
         tag_q        <= '0;
         fma_en_q     <= 1'b0;
         rsp_result_q <= '0;
         rsp_fpcsr_q  <= '0;
         rsp_tag_q    <= '0;
         sticky_q     <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         opa_q        <= opa_d;
         opb_q        <= opb_d;
         opc_q        <= opc_d;
         op_q         <= op_d;
         tag_q        <= tag_d;
         fma_en_q     <= fma_en_d;
         rsp_result_q <= rsp_result_d;
         rsp_fpcsr_q  <= rsp_fpcsr_d;
         rsp_tag_q    <= rsp_tag_d;
         sticky_q     <= sticky_d;
      end
   end

   assign cmd_ready     = !fifo_full;
   assign rsp_valid     = (state_q == ST_DONE);
   assign rsp_result    = rsp_result_q;
   assign rsp_fpcsr     = rsp_fpcsr_q;
   assign rsp_tag       = rsp_tag_q;
   assign fma_enable    = fma_en_q;
   assign fma_operand_a = opa_q;
   assign fma_operand_b = opb_q;
   assign fma_operand_c = opc_q;
   assign fma_operation = op_q;
   assign sticky_fpcsr  = sticky_q;
   assign busy          = (state_q != ST_IDLE) || !fifo_empty;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_bf16_fma_ctrl.sv
// Directed bench for bf16_fma_ctrl with a small real-valued BF16 datapath model
// (latency 1) and an in-order response scoreboard.
module tb_bf16_fma_ctrl;
   import bf16_pkg::*;

   logic        clk;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_op;
   logic [15:0] cmd_a, cmd_b, cmd_c;
   logic [1:0]  cmd_tag;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_result;
   logic [3:0]  rsp_fpcsr;
   logic [1:0]  rsp_tag;
   logic        fma_enable;
   logic [15:0] fma_operand_a, fma_operand_b, fma_operand_c;
   logic [3:0]  fma_operation;
   logic [15:0] fma_result;
   logic [3:0]  fma_fpcsr;
   logic [3:0]  sticky_fpcsr;
   logic        sticky_clear;
   logic        busy;
   state_e      dbg_state;

   logic [3:0]  dp_fpcsr_cfg;
   int          n_checks;
   int          n_errors;
   int          en_count;
   int          en_base;
   int          stale;
   logic [21:0] exp_q[$];

   bf16_fma_ctrl #(
      .FIFO_DEPTH  (4),
      .FMA_LATENCY (1)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_op        (cmd_op),
      .cmd_a         (cmd_a),
      .cmd_b         (cmd_b),
      .cmd_c         (cmd_c),
      .cmd_tag       (cmd_tag),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_result    (rsp_result),
      .rsp_fpcsr     (rsp_fpcsr),
      .rsp_tag       (rsp_tag),
      .fma_enable    (fma_enable),
      .fma_operand_a (fma_operand_a),
      .fma_operand_b (fma_operand_b),
      .fma_operand_c (fma_operand_c),
      .fma_operation (fma_operation),
      .fma_result    (fma_result),
      .fma_fpcsr     (fma_fpcsr),
      .sticky_fpcsr  (sticky_fpcsr),
      .sticky_clear  (sticky_clear),
      .busy          (busy),
      .dbg_state     (dbg_state)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- datapath model ----------------
   function automatic real bf2r(input logic [15:0] x);
      logic [63:0] d;
      logic [10:0] e;
      if (x[14:0] == 15'd0) begin
         d = {x[15], 63'd0};
      end else begin
         e = {3'b000, x[14:7]} + 11'd896;
         d = {x[15], e, x[6:0], 45'd0};
      end
      return $bitstoreal(d);
   endfunction

   function automatic logic [15:0] r2bf(input real r);
      logic [63:0] d;
      logic [10:0] e;
      d = $realtobits(r);
      if (d[62:0] == 63'd0) begin
         return {d[63], 15'd0};
      end
      e = d[62:52] - 11'd896;
      return {d[63], e[7:0], d[51:45]};
   endfunction

   function automatic logic [15:0] dp_compute(input logic [3:0] op, input logic [15:0] a,
                                              input logic [15:0] b, input logic [15:0] c);
      real ra, rb, rc, r;
      ra = bf2r(a);
      rb = bf2r(b);
      rc = bf2r(c);
      case (op)
         OP_FMADD:  r = ra * rb + rc;
         OP_FMSUB:  r = ra * rb - rc;
         OP_FNMSUB: r = -(ra * rb) + rc;
         OP_FNMADD: r = -(ra * rb) - rc;
         OP_ADD:    r = rb + rc;
         OP_SUB:    r = rb - rc;
         OP_MUL:    r = ra * rb;
         default:   r = 0.0;
      endcase
      return r2bf(r);
   endfunction

   always @(posedge clk) begin
      if (fma_enable) begin
         fma_result <= dp_compute(fma_operation, fma_operand_a, fma_operand_b, fma_operand_c);
         fma_fpcsr  <= dp_fpcsr_cfg;
      end
   end

   always @(negedge clk) begin
      if (fma_enable) en_count = en_count + 1;
   end

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (got !== exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- drivers ----------------
   // Called at a negedge; returns at the negedge after the accepting edge with cmd_valid still high.
   task automatic send_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [1:0] tag);
      int n;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      cmd_c     = c;
      cmd_tag   = tag;
      cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check_eq("send_timeout", 32'(cmd_ready), 32'd1);
      @(negedge clk);
   endtask

   task automatic wait_state(input string tag, input state_e st);
      int n;
      n = 0;
      while (dbg_state != st && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_eq(tag, 32'(dbg_state), 32'(st));
   endtask

   task automatic collect_rsp(input string tag);
      logic [21:0] e;
      int n;
      e = exp_q.pop_front();
      n = 0;
      while (!rsp_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_eq({tag, "_valid"}, 32'(rsp_valid), 32'd1);
      check_eq({tag, "_result"}, 32'(rsp_result), 32'(e[21:6]));
      check_eq({tag, "_fpcsr"}, 32'(rsp_fpcsr), 32'(e[5:2]));
      check_eq({tag, "_tag"}, 32'(rsp_tag), 32'(e[1:0]));
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   logic [15:0] full_b [5];

   // ---------------- main sequence ----------------
   initial begin
      n_checks     = 0;
      n_errors     = 0;
      en_count     = 0;
      reset        = 1'b1;
      cmd_valid    = 1'b0;
      cmd_op       = '0;
      cmd_a        = '0;
      cmd_b        = '0;
      cmd_c        = '0;
      cmd_tag      = '0;
      rsp_ready    = 1'b0;
      sticky_clear = 1'b0;
      dp_fpcsr_cfg = 4'b0000;
      full_b[0] = 16'h3F80;
      full_b[1] = 16'h4000;
      full_b[2] = 16'h4040;
      full_b[3] = 16'h4080;
      full_b[4] = 16'h40A0;

      repeat (3) @(negedge clk);
      check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_sticky", 32'(sticky_fpcsr), 32'd0);
      check_eq("rst_fma_en", 32'(fma_enable), 32'd0);
      check_eq("rst_result", 32'(rsp_result), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // FMADD 1*2+1 = 3 with latency check
      en_base = en_count;
      send_cmd(OP_FMADD, 16'h3F80, 16'h4000, 16'h3F80, 2'd2);
      cmd_valid = 1'b0;
      check_eq("fmadd_busy", 32'(busy), 32'd1);
      @(negedge clk);
      check_eq("fmadd_e1_valid", 32'(rsp_valid), 32'd0);
      check_eq("fmadd_e1_en", 32'(fma_enable), 32'd1);
      @(negedge clk);
      check_eq("fmadd_e2_valid", 32'(rsp_valid), 32'd0);
      check_eq("fmadd_e2_en", 32'(fma_enable), 32'd0);
      check_eq("fmadd_hold_a", 32'(fma_operand_a), 32'h3F80);
      check_eq("fmadd_hold_b", 32'(fma_operand_b), 32'h4000);
      check_eq("fmadd_hold_c", 32'(fma_operand_c), 32'h3F80);
      check_eq("fmadd_hold_op", 32'(fma_operation), 32'(OP_FMADD));
      @(negedge clk);
      check_eq("fmadd_e3_valid", 32'(rsp_valid), 32'd1);
      exp_q.push_back({16'h4040, 4'b0000, 2'd2});
      collect_rsp("fmadd");
      check_eq("fmadd_en_pulses", 32'(en_count - en_base), 32'd1);
      check_eq("fmadd_idle_busy", 32'(busy), 32'd0);

      // back-to-back MUL then ADD
      exp_q.push_back({16'h4080, 4'b0000, 2'd1});
      exp_q.push_back({16'h4000, 4'b0000, 2'd3});
      send_cmd(OP_MUL, 16'h4000, 16'h4000, 16'h0000, 2'd1);
      send_cmd(OP_ADD, 16'h1234, 16'h3F80, 16'h3F80, 2'd3);
      cmd_valid = 1'b0;
      collect_rsp("b2b_mul");
      collect_rsp("b2b_add");

      // illegal opcode
      en_base = en_count;
      exp_q.push_back({16'h7FC0, 4'b1000, 2'd0});
      send_cmd(4'b0000, 16'h1111, 16'h2222, 16'h3333, 2'd0);
      cmd_valid = 1'b0;
      collect_rsp("illegal");
      check_eq("illegal_sticky", 32'(sticky_fpcsr), 32'h8);
      check_eq("illegal_no_en", 32'(en_count - en_base), 32'd0);

      // sticky_clear coinciding with capture: 2 - 1 = 1
      dp_fpcsr_cfg = 4'b0001;
      send_cmd(OP_SUB, 16'h0000, 16'h4000, 16'h3F80, 2'd1);
      cmd_valid = 1'b0;
      wait_state("sclr_wait", ST_WAIT);
      sticky_clear = 1'b1;
      @(negedge clk);
      sticky_clear = 1'b0;
      check_eq("sclr_sticky", 32'(sticky_fpcsr), 32'h1);
      exp_q.push_back({16'h3F80, 4'b0001, 2'd1});
      collect_rsp("sclr");
      dp_fpcsr_cfg = 4'b0000;

      // FIFO full: 2 * {1,2,3,4,5}, sixth offer refused
      for (int i = 0; i < 6; i++) begin
         cmd_op    = OP_MUL;
         cmd_a     = 16'h4000;
         cmd_b     = (i < 5) ? full_b[i] : 16'h4100;
         cmd_c     = 16'h0000;
         cmd_tag   = 2'(i);
         cmd_valid = 1'b1;
         check_eq($sformatf("full_rdy%0d", i), 32'(cmd_ready), (i < 5) ? 32'd1 : 32'd0);
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      check_eq("full_still_full", 32'(cmd_ready), 32'd0);
      exp_q.push_back({16'h4000, 4'b0000, 2'd0});
      exp_q.push_back({16'h4080, 4'b0000, 2'd1});
      exp_q.push_back({16'h40C0, 4'b0000, 2'd2});
      exp_q.push_back({16'h4100, 4'b0000, 2'd3});
      exp_q.push_back({16'h4120, 4'b0000, 2'd0});
      for (int i = 0; i < 5; i++) begin
         collect_rsp($sformatf("drain%0d", i));
      end
      repeat (3) @(negedge clk);
      check_eq("drain_extra", 32'(rsp_valid), 32'd0);
      check_eq("drain_busy", 32'(busy), 32'd0);

      // reset while in WAIT with another command queued
      send_cmd(OP_FMADD, 16'h3F80, 16'h4000, 16'h3F80, 2'd1);
      send_cmd(OP_MUL, 16'h4000, 16'h4000, 16'h0000, 2'd2);
      cmd_valid = 1'b0;
      wait_state("rstw_wait", ST_WAIT);
      #2 reset = 1'b1;
      #1;
      check_eq("rstw_state", 32'(dbg_state), 32'(ST_IDLE));
      check_eq("rstw_rsp_valid", 32'(rsp_valid), 32'd0);
      check_eq("rstw_cmd_ready", 32'(cmd_ready), 32'd1);
      check_eq("rstw_fma_en", 32'(fma_enable), 32'd0);
      check_eq("rstw_busy", 32'(busy), 32'd0);
      check_eq("rstw_sticky", 32'(sticky_fpcsr), 32'd0);
      check_eq("rstw_rsp", 32'({rsp_result, rsp_fpcsr, rsp_tag}), 32'd0);
      check_eq("rstw_opnds", 32'({fma_operand_a, fma_operand_b}), 32'd0);
      check_eq("rstw_opc_op", 32'({fma_operand_c, fma_operation}), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      rsp_ready = 1'b1;
      stale = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (rsp_valid || busy) stale++;
      end
      rsp_ready = 1'b0;
      check_eq("rstw_no_stale", 32'(stale), 32'd0);
      check_eq("rstw_exp_empty", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
